fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the decode stage. Generates the fetch PC, drives the synchronous instruction memory and presents ir/pc1 to decode. Holds the presented instruction while decode is stalled, with no lost or duplicated instruction. Applies branch/jump redirects from execute and raises the decode flush.

---
 rtl/fetch_stage.sv | 188 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage that sits directly in front of decode. It generates
// the fetch PC and drives a synchronous instruction memory that has one cycle
// of read latency. It presents ir/pc1 to decode. While decode stalls, the
// presented instruction is held so that no instruction is lost or duplicated.
// Taken branch and jump redirects from execute reload the fetch PC and insert
// one bubble. The decode flush is raised combinationally in the redirect cycle.
//
// Parameters:
//   RESET_PC     first PC fetched after reset
//   NOP_INSN     encoding presented when no valid instruction is available
//
// Ports:
//   clk          clock; all state updates on posedge
//   rst          synchronous, active-high reset (overrides redirect/stall)
//   stall        decode does not consume ir at this edge
//   redirect     execute resolved a taken branch/JAL/JALR
//   redirect_pc  redirect target, valid while redirect=1
//   imem_addr    instruction memory read address (= fetch PC register)
//   imem_rdata   memory data for the address presented before the last edge
//   ir           instruction to decode
//   pc1          PC of ir
//   ir_valid     ir is a real fetched instruction
//   flush        decode flush, combinationally equal to redirect
//   misalign_fault  (only with FETCH_MISALIGN_TRAP_EN) sticky misaligned-target
//                   fault indicator
//
// Configuration macro:
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect to a target that is not
//                           word-aligned enters a sticky FAULT state that only
//                           rst can leave. When undefined, the two low
//                           target bits are cleared instead.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc1,
    output logic        ir_valid,
    output logic        flush
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_fault
`endif
);

    // EMPTY: nothing valid in flight (after reset or redirect)
    // RUN:   imem_rdata holds the word for req_pc and is presented directly
    // HOLD:  decode stalled; the captured word is replayed from hold_ir
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StRun   = 2'd1,
        StHold  = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        StFault = 2'd3
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;       // next PC to be read from imem
    logic [31:0] req_pc_q, req_pc_d; // PC whose word is currently on imem_rdata
    logic [31:0] hold_ir_q, hold_ir_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    // -----------------------------------------------------------------------
    // Next-state logic. Priority is redirect > stall > advance; rst is
    // handled in the register block and overrides all of them.
    // -----------------------------------------------------------------------
    always_comb begin : next_state
        state_d   = state_q;
        fpc_d     = fpc_q;
        req_pc_d  = req_pc_q;
        hold_ir_d = hold_ir_q;
        hold_pc_d = hold_pc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
        if (state_q == StFault) begin
            // Sticky: only rst leaves FAULT, so redirect and stall are ignored.
        end else
`endif
        if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            fpc_d = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = StFault;
            end else begin
                state_d = StEmpty;
            end
`else
            // Misaligned targets are silently aligned down to a word.
            fpc_d   = redirect_pc & ~32'h0000_0003;
            state_d = StEmpty;
`endif
        end else if (stall) begin
            // Only RUN must capture the word: after this edge imem_rdata
            // changes to the re-read of fpc. EMPTY and HOLD already hold.
            if (state_q == StRun) begin
                hold_ir_d = imem_rdata;
                hold_pc_d = req_pc_q;
                state_d   = StHold;
            end
        end else begin
            // Advance. The read of fpc is already under way, which makes
            // stall release zero-bubble.
            req_pc_d = fpc_q;
            fpc_d    = fpc_q + 32'd4;
            state_d  = StRun;
        end
    end

    // -----------------------------------------------------------------------
    // State registers with synchronous active-high reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state_q   <= StEmpty;
            fpc_q     <= RESET_PC;
            req_pc_q  <= 32'h0000_0000;
            hold_ir_q <= NOP_INSN;
            hold_pc_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            req_pc_q  <= req_pc_d;
            hold_ir_q <= hold_ir_d;
            hold_pc_q <= hold_pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. They are decoded from registered state only, except that ir
    // in RUN passes imem_rdata straight through. The memory output is
    // itself registered.
    // -----------------------------------------------------------------------
    assign imem_addr = fpc_q;
    assign flush     = redirect;

    always_comb begin : outputs
        ir       = NOP_INSN;
        pc1      = req_pc_q;
        ir_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_fault = 1'b0;
`endif
        case (state_q)
            StEmpty: begin
                ir       = NOP_INSN;
                pc1      = req_pc_q;
                ir_valid = 1'b0;
            end
            StRun: begin
                ir       = imem_rdata;
                pc1      = req_pc_q;
                ir_valid = 1'b1;
            end
            StHold: begin
                ir       = hold_ir_q;
                pc1      = hold_pc_q;
                ir_valid = 1'b1;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            StFault: begin
                ir             = NOP_INSN;
                pc1            = fpc_q;
                ir_valid       = 1'b0;
                misalign_fault = 1'b1;
            end
`endif
            default: begin
                ir       = NOP_INSN;
                pc1      = req_pc_q;
                ir_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. There are two DUT instances:
//   dut    RESET_PC = 0, checked against a behavioural model each cycle
//   dut_w  RESET_PC = 0xFFFF_FFF8, used for the PC wrap-around case
//
// The model tracks only what decode sees. It holds the presented PC, a valid
// flag, the next fetch PC and a sticky fault flag, and applies the
// rst > redirect > stall > advance rules to them. The expected ir is the
// memory word at the presented PC, or NOP when nothing is valid.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] RST_PCW = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata, ir, pc1;
    logic        ir_valid, flush, mfault;
    logic [31:0] imem_addr_w, imem_rdata_w, ir_w, pc1_w;
    logic        ir_valid_w, flush_w, mfault_w;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_next;
    logic        m_valid, m_fault;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .pc1         (pc1),
        .ir_valid    (ir_valid),
        .flush       (flush)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault (mfault)
`endif
    );

    fetch_stage #(.RESET_PC(RST_PCW), .NOP_INSN(NOP)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr_w),
        .imem_rdata  (imem_rdata_w),
        .ir          (ir_w),
        .pc1         (pc1_w),
        .ir_valid    (ir_valid_w),
        .flush       (flush_w)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault (mfault_w)
`endif
    );

`ifndef FETCH_MISALIGN_TRAP_EN
    assign mfault   = 1'b0;
    assign mfault_w = 1'b0;
`endif

    logic [97:0] act;
    logic [96:0] act_w;
    assign act   = {ir, pc1, ir_valid, imem_addr, mfault};
    assign act_w = {ir_w, pc1_w, ir_valid_w, imem_addr_w};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a >> 2) * 32'h0001_0003 + 32'h0000_0107;
    endfunction

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        imem_rdata   <= word(imem_addr);
        imem_rdata_w <= word(imem_addr_w);
    end

    function automatic logic [97:0] exp_vec();
        if (m_fault) return {NOP, m_next, 1'b0, m_next, 1'b1};
        return {(m_valid ? word(m_pc) : NOP), m_pc, m_valid, m_next, 1'b0};
    endfunction

    // Drive inputs just after an active edge.
    task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic rs);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        rst         = rs;
        #1;
    endtask

    // Advance one edge, apply the rules to the model, then settle.
    task automatic clock();
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_next = RST_PC; m_fault = 1'b0;
        end else if (m_fault) begin
            // sticky until reset
        end else if (redirect) begin
            m_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_next = redirect_pc;
            if (redirect_pc % 4 != 0) m_fault = 1'b1;
`else
            m_next = redirect_pc - (redirect_pc % 4);
`endif
        end else if (!stall) begin
            m_pc    = m_next;
            m_next  = m_next + 32'd4;
            m_valid = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, $urandom, 1'b1);
        total++;
        if (flush !== 1'b1) begin
            bad++; $display("FAIL reset_flush: got %b want 1", flush);
        end
        clock();
        total++;
        if (act !== {NOP, 32'h0, 1'b0, RST_PC, 1'b0}) begin
            bad++; $display("FAIL reset_state: got %h want %h", act, {NOP, 32'h0, 1'b0, RST_PC, 1'b0});
        end
        total++;
        if (act_w !== {NOP, 32'h0, 1'b0, RST_PCW}) begin
            bad++; $display("FAIL reset_state_w: got %h want %h", act_w, {NOP, 32'h0, 1'b0, RST_PCW});
        end
    endtask

    task automatic test_advance();
        logic [31:0] p;
        for (int i = 0; i < 3; i++) begin
            p = 32'(i * 4);
            drive(1'b0, 1'b0, 32'h0, 1'b0);
            clock();
            total++;
            if (act !== {word(p), p, 1'b1, p + 32'd4, 1'b0}) begin
                bad++; $display("FAIL advance_%0d: got %h want %h", i, act, {word(p), p, 1'b1, p + 32'd4, 1'b0});
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0);
            clock();
            total++;
            if (act !== {word(32'h8), 32'h8, 1'b1, 32'hC, 1'b0}) begin
                bad++; $display("FAIL stall_hold_%0d: got %h want %h", i, act, {word(32'h8), 32'h8, 1'b1, 32'hC, 1'b0});
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        clock();
        total++;
        if (act !== {word(32'hC), 32'hC, 1'b1, 32'h10, 1'b0}) begin
            bad++; $display("FAIL stall_release: got %h want %h", act, {word(32'hC), 32'hC, 1'b1, 32'h10, 1'b0});
        end
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        clock();
        drive(1'b0, 1'b1, 32'h100, 1'b0);
        total++;
        if (flush !== 1'b1 || pc1 !== 32'h10) begin
            bad++; $display("FAIL redir_flush: got flush=%b pc1=%h want 1/00000010", flush, pc1);
        end
        clock();
        total++;
        if (act !== {NOP, 32'h10, 1'b0, 32'h100, 1'b0}) begin
            bad++; $display("FAIL redir_bubble: got %h want %h", act, {NOP, 32'h10, 1'b0, 32'h100, 1'b0});
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total++;
        if (flush !== 1'b0) begin
            bad++; $display("FAIL redir_flush_drop: got %b want 0", flush);
        end
        for (int i = 0; i < 2; i++) begin
            clock();
            total++;
            if (pc1 !== 32'h100 + 32'(4 * i) || ir !== word(32'h100 + 32'(4 * i)) || ir_valid !== 1'b1) begin
                bad++; $display("FAIL redir_target_%0d: got pc1=%h ir=%h v=%b want pc1=%h", i, pc1, ir, ir_valid, 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_hold();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        clock();
        drive(1'b1, 1'b1, 32'h200, 1'b0);
        clock();
        total++;
        if (act !== {NOP, 32'h104, 1'b0, 32'h200, 1'b0}) begin
            bad++; $display("FAIL hold_redir_bubble: got %h want %h", act, {NOP, 32'h104, 1'b0, 32'h200, 1'b0});
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        clock();
        total++;
        if (act !== {word(32'h200), 32'h200, 1'b1, 32'h204, 1'b0}) begin
            bad++; $display("FAIL hold_redir_target: got %h want %h", act, {word(32'h200), 32'h200, 1'b1, 32'h204, 1'b0});
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seq [3];
        seq[0] = 32'hFFFF_FFF8; seq[1] = 32'hFFFF_FFFC; seq[2] = 32'h0000_0000;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        clock();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0);
            clock();
            total++;
            if (act_w !== {word(seq[i]), seq[i], 1'b1, seq[i] + 32'd4}) begin
                bad++; $display("FAIL wrap_%0d: got %h want %h", i, act_w, {word(seq[i]), seq[i], 1'b1, seq[i] + 32'd4});
            end
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        clock();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        clock();
        total++;
        if (act_w !== {NOP, 32'h0, 1'b0, RST_PCW} || act !== {NOP, 32'h0, 1'b0, RST_PC, 1'b0}) begin
            bad++; $display("FAIL rst_in_stall: got %h / %h want empty at reset pc", act_w, act);
        end
    endtask

    task automatic test_misalign();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        clock();
        clock();
        drive(1'b0, 1'b1, 32'h102, 1'b0);
        clock();
`ifdef FETCH_MISALIGN_TRAP_EN
        total++;
        if (act !== {NOP, 32'h102, 1'b0, 32'h102, 1'b1}) begin
            bad++; $display("FAIL misalign_enter: got %h want %h", act, {NOP, 32'h102, 1'b0, 32'h102, 1'b1});
        end
        drive(1'b0, 1'b1, 32'h200, 1'b0);
        clock();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        clock();
        total++;
        if (act !== {NOP, 32'h102, 1'b0, 32'h102, 1'b1}) begin
            bad++; $display("FAIL misalign_sticky: got %h want %h", act, {NOP, 32'h102, 1'b0, 32'h102, 1'b1});
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        clock();
        total++;
        if (act !== {NOP, 32'h0, 1'b0, RST_PC, 1'b0}) begin
            bad++; $display("FAIL misalign_clear: got %h want %h", act, {NOP, 32'h0, 1'b0, RST_PC, 1'b0});
        end
`else
        total++;
        if (act !== {NOP, 32'h4, 1'b0, 32'h100, 1'b0}) begin
            bad++; $display("FAIL misalign_align: got %h want %h", act, {NOP, 32'h4, 1'b0, 32'h100, 1'b0});
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        clock();
        total++;
        if (act !== {word(32'h100), 32'h100, 1'b1, 32'h104, 1'b0}) begin
            bad++; $display("FAIL misalign_fetch: got %h want %h", act, {word(32'h100), 32'h100, 1'b1, 32'h104, 1'b0});
        end
`endif
    endtask

    task automatic test_random();
        logic s, r, rs;
        logic [31:0] rp;
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 2) == 0);
            rp = $urandom;
            if ($urandom_range(0, 15) != 0) rp[1:0] = 2'b00;
            drive(s, r, rp, rs);
            total++;
            if (flush !== r) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_flush_%0d: got %b want %b", i, flush, r);
            end
            clock();
            total++;
            if (act !== exp_vec()) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_out_%0d: got %h want %h", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        m_pc = 32'h0; m_next = RST_PC; m_valid = 1'b0; m_fault = 1'b0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_advance();
        test_stall();
        test_redirect();
        test_redirect_hold();
        test_wrap();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
